// File: rtl/grf.sv
// 32 x 32 general register file: two combinational read ports, one synchronous write port, $0 hardwired to zero.
// Optional same-cycle write-through on the read ports when GRF_BYPASS_EN is defined.
module grf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] grf_RA1,
  input  logic [ADDR_W-1:0] grf_RA2,
  input  logic [ADDR_W-1:0] grf_WA,
  input  logic [DATA_W-1:0] grf_WD,
  input  logic              grf_WE,
  input  logic [31:0]       grf_PC,
  output logic [DATA_W-1:0] grf_RD1,
  output logic [DATA_W-1:0] grf_RD2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              wr_en;

  // reset wins over a coincident write; $0 is never a write target
  assign wr_en = !reset && grf_WE && (grf_WA != '0);

  always_comb begin
    regs_d = regs_q;
    if (reset) begin
      regs_d = '{default: '0};
    end else if (wr_en) begin
      regs_d[grf_WA] = grf_WD;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    grf_RD1 = (grf_RA1 == '0) ? '0 : regs_q[grf_RA1];
    grf_RD2 = (grf_RA2 == '0) ? '0 : regs_q[grf_RA2];
`ifdef GRF_BYPASS_EN
    if (wr_en && (grf_WA == grf_RA1)) grf_RD1 = grf_WD;
    if (wr_en && (grf_WA == grf_RA2)) grf_RD2 = grf_WD;
`endif
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (wr_en) $display("@%h: $%d <= %h", grf_PC, grf_WA, grf_WD);
  end
`endif

endmodule

// File: tb/tb_grf.sv
// Directed self-checking bench for grf; expectations follow the build (GRF_BYPASS_EN on or off).
module tb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  grf_RA1, grf_RA2, grf_WA;
  logic [31:0] grf_WD, grf_PC;
  logic        grf_WE;
  logic [31:0] grf_RD1, grf_RD2;

  int checks_total  = 0;
  int checks_passed = 0;

  grf dut (
    .clk     (clk),
    .reset   (reset),
    .grf_RA1 (grf_RA1),
    .grf_RA2 (grf_RA2),
    .grf_WA  (grf_WA),
    .grf_WD  (grf_WD),
    .grf_WE  (grf_WE),
    .grf_PC  (grf_PC),
    .grf_RD1 (grf_RD1),
    .grf_RD2 (grf_RD2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // inputs change 1 time unit after the rising edge, reads are sampled 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] wa, input logic [31:0] wd);
    grf_WE = 1'b1; grf_WA = wa; grf_WD = wd; grf_PC = grf_PC + 32'd4;
    tick();
    grf_WE = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pre;
    reset = 1'b1; grf_WE = 1'b0; grf_WA = '0; grf_WD = '0; grf_PC = 32'h0000_3000;
    grf_RA1 = '0; grf_RA2 = '0;
    tick();
    reset = 1'b0;

    // 1: everything reads zero after reset
    grf_RA1 = 5'd5; grf_RA2 = 5'd31; #1;
    check("reset_rd1_r5", grf_RD1, 32'h0);
    check("reset_rd2_r31", grf_RD2, 32'h0);

    // 2: plain write then read
    write_reg(5'd8, 32'h1234_5678);
    grf_RA1 = 5'd8; #1;
    check("wr_r8", grf_RD1, 32'h1234_5678);

    // 3: $0 write discarded, never bypassed
    grf_WE = 1'b1; grf_WA = 5'd0; grf_WD = 32'hFFFF_FFFF; grf_RA1 = 5'd0; grf_RA2 = 5'd0; #1;
    check("r0_pre_edge", grf_RD1, 32'h0);
    tick();
    grf_WE = 1'b0; #1;
    check("r0_rd1", grf_RD1, 32'h0);
    check("r0_rd2", grf_RD2, 32'h0);

    // 4: same-cycle read of a register being written
    write_reg(5'd9, 32'hA);
    grf_WE = 1'b1; grf_WA = 5'd9; grf_WD = 32'hB; grf_RA2 = 5'd9; #1;
`ifdef GRF_BYPASS_EN
    exp_pre = 32'hB;
`else
    exp_pre = 32'hA;
`endif
    check("raw_pre_edge", grf_RD2, exp_pre);
    tick();
    grf_WE = 1'b0; #1;
    check("raw_post_edge", grf_RD2, 32'hB);

    // 5: reset beats a coincident write and clears everything
    write_reg(5'd3, 32'd7);
    grf_RA1 = 5'd3; #1;
    check("r3_before_reset", grf_RD1, 32'd7);
    reset = 1'b1; grf_WE = 1'b1; grf_WA = 5'd3; grf_WD = 32'd9;
    tick();
    reset = 1'b0; grf_WE = 1'b0;
    grf_RA1 = 5'd3; grf_RA2 = 5'd8; #1;
    check("reset_wins_r3", grf_RD1, 32'h0);
    check("reset_clears_r8", grf_RD2, 32'h0);
    write_reg(5'd3, 32'd5);
    #1;
    check("write_after_reset", grf_RD1, 32'd5);

    // 6: fill r1..r31 with their index, read pairs (i, 32-i)
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
    for (int i = 1; i < 32; i++) begin
      grf_RA1 = 5'(i); grf_RA2 = 5'(32 - i); #1;
      check($sformatf("pair_rd1_%0d", i), grf_RD1, 32'(i));
      check($sformatf("pair_rd2_%0d", i), grf_RD2, 32'(32 - i));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
